// File: rtl/jtkcpu_stkseq_pkg.sv
// Shared types for the push/pull stack sequencer:
// FSM state encoding and the default 16-bit register mask.
package jtkcpu_stkseq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PICK,
      ST_BUS,
      ST_FIN
   } st_e;

   // CC, A, B, DP are 8-bit; X, U/S, Y, PC are 16-bit
   localparam logic [7:0] WIDE_DEF = 8'hF0;

endpackage

// File: rtl/jtkcpu_prienc.sv
// Priority encoder over a register mask, scanning either
// from the top bit down or from bit 0 up.
module jtkcpu_prienc #(
   parameter int N  = 8,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  vec_i,
   input  logic          hi_first_i,
   output logic [SW-1:0] idx_o,
   output logic          valid_o
);

   // The last match in each loop wins
   always_comb begin
      idx_o   = '0;
      valid_o = |vec_i;
      if (hi_first_i) begin
         for (int i = 0; i < N; i++)
            if (vec_i[i]) idx_o = SW'(i);
      end else begin
         for (int i = N-1; i >= 0; i--)
            if (vec_i[i]) idx_o = SW'(i);
      end
   end

endmodule

// File: rtl/jtkcpu_stkseq.sv
// Push/pull sequencer: walks a register mask a byte at a time,
// drives the byte bus and steps the stack pointer.
module jtkcpu_stkseq
   import jtkcpu_stkseq_pkg::*;
#(
   parameter int              NREG = 8,
   parameter int              AW   = 16,
   parameter logic [NREG-1:0] WIDE = WIDE_DEF,
   parameter int              SW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cen,
   input  logic            start,
   input  logic            pull,
   input  logic [NREG-1:0] mask,
   input  logic [AW-1:0]   sp_in,
   input  logic [7:0]      reg_byte,
   input  logic [7:0]      din,
   input  logic            ack,
   output logic [SW-1:0]   sel,
   output logic            sel_hi,
   output logic [AW-1:0]   addr,
   output logic [7:0]      dout,
   output logic            req,
   output logic            we,
   output logic            wr_en,
   output logic [7:0]      wr_data,
   output logic [AW-1:0]   sp_out,
   output logic            busy,
   output logic            done
);

   st_e             st_q;
   logic            pull_q;
   logic [NREG-1:0] rem_q;
   logic [NREG-1:0] rem_d;
   logic [SW-1:0]   sel_q;
   logic            hi_q;
   logic [AW-1:0]   addr_q;
   logic [AW-1:0]   sp_q;
   logic            req_q;
   logic            we_q;
   logic            busy_q;
   logic            done_q;
   logic [SW-1:0]   pe_idx;
   logic            pe_vld;
   logic            xfer;
   logic            first_wide;

   jtkcpu_prienc #(.N(NREG), .SW(SW)) u_prienc (
      .vec_i      (rem_q),
      .hi_first_i (~pull_q),
      .idx_o      (pe_idx),
      .valid_o    (pe_vld)
   );

   assign xfer  = cen & (st_q == ST_BUS) & ack;
   assign rem_d = rem_q & ~(NREG'(1) << sel_q);
   // Push starts wide regs on the low byte, pull on the high byte
   assign first_wide = WIDE[sel_q] & (hi_q == pull_q);

   assign sel     = sel_q;
   assign sel_hi  = hi_q;
   assign addr    = addr_q;
   assign dout    = reg_byte;
   assign req     = req_q;
   assign we      = we_q;
   assign wr_en   = xfer & pull_q;
   assign wr_data = wr_en ? din : 8'h00;
   assign sp_out  = sp_q;
   assign busy    = busy_q;
   assign done    = done_q & cen;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q   <= ST_IDLE;
         pull_q <= 1'b0;
         rem_q  <= '0;
         sel_q  <= '0;
         hi_q   <= 1'b0;
         addr_q <= '0;
         sp_q   <= '0;
         req_q  <= 1'b0;
         we_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (cen) begin
         done_q <= 1'b0;
         unique case (st_q)
            ST_IDLE: begin
               if (start) begin
                  pull_q <= pull;
                  rem_q  <= mask;
                  sp_q   <= sp_in;
                  busy_q <= 1'b1;
                  st_q   <= (mask == '0) ? ST_FIN : ST_PICK;
               end
            end
            ST_PICK: begin
               if (pe_vld) begin
                  sel_q  <= pe_idx;
                  hi_q   <= WIDE[pe_idx] & pull_q;
                  req_q  <= 1'b1;
                  we_q   <= ~pull_q;
                  addr_q <= pull_q ? sp_q : sp_q - AW'(1);
                  st_q   <= ST_BUS;
               end else begin
                  st_q   <= ST_FIN;
               end
            end
            ST_BUS: begin
               if (ack) begin
                  sp_q <= pull_q ? sp_q + AW'(1) : sp_q - AW'(1);
                  if (first_wide) begin
                     hi_q   <= ~hi_q;
                     addr_q <= pull_q ? sp_q + AW'(1) : sp_q - AW'(2);
                  end else begin
                     rem_q <= rem_d;
                     req_q <= 1'b0;
                     we_q  <= 1'b0;
                     st_q  <= (rem_d == '0) ? ST_FIN : ST_PICK;
                  end
               end
            end
            ST_FIN: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
               st_q   <= ST_IDLE;
            end
            default: st_q <= ST_IDLE;
         endcase
      end
   end

endmodule
